// File: rtl/transmissor_ascii_param_if.sv
// Handshake and data bundle between the torreta formatting logic and the ASCII serial transmitter.
// LARGURA must equal 7*NUM_CAMPOS*(DIGITOS+1) of the transmitter attached to it.
interface transmissor_ascii_param_if #(
  parameter int LARGURA = 56
);
  logic               iniciar;
  logic               cancelar;
  logic [LARGURA-1:0] caracteres;
  logic               dado_serial;
  logic               ocupado;
  logic               pronto;
  logic               abortado;

  modport master (
    output iniciar, cancelar, caracteres,
    input  dado_serial, ocupado, pronto, abortado
  );

  modport slave (
    input  iniciar, cancelar, caracteres,
    output dado_serial, ocupado, pronto, abortado
  );
endinterface

// File: rtl/transmissor_ascii_param.sv
// Serialises NUM_CAMPOS fields of DIGITOS ASCII digits plus a terminator each onto an async serial line,
// with configurable parity and stop bits, a start/cancel handshake and fully registered outputs.
module transmissor_ascii_param #(
  parameter int NUM_CAMPOS     = 2,
  parameter int DIGITOS        = 3,
  parameter int CICLOS_POR_BIT = 434,
  parameter int PARIDADE       = 1,
  parameter int STOP_BITS      = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  transmissor_ascii_param_if.slave bus
);

  localparam int TOTAL   = NUM_CAMPOS * (DIGITOS + 1);
  localparam int BITS    = 1 + 7 + ((PARIDADE != 0) ? 1 : 0) + STOP_BITS;
  localparam int LARGURA = 7 * TOTAL;
  localparam int BAUD_W  = $clog2(CICLOS_POR_BIT);
  localparam int BIT_W   = $clog2(BITS);
  localparam int CHAR_W  = (TOTAL > 1) ? $clog2(TOTAL) : 1;

  localparam logic [BAUD_W-1:0] BAUD_ULTIMO = BAUD_W'(CICLOS_POR_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_ULTIMO  = BIT_W'(BITS - 1);
  localparam logic [CHAR_W-1:0] CHAR_ULTIMO = CHAR_W'(TOTAL - 1);

  typedef enum logic [1:0] {
    OCIOSO,
    TRANSMITE,
    FINAL,
    CANCELADO
  } estado_t;

  estado_t             estado, estado_prox;
  logic [BAUD_W-1:0]   baud, baud_prox;
  logic [BIT_W-1:0]    bit_idx, bit_prox;
  logic [CHAR_W-1:0]   char_idx, char_prox;
  logic [LARGURA-1:0]  registro, registro_prox;
  logic                cancela, cancela_prox;
  logic [6:0]          char_atual;
  logic [BITS-1:0]     quadro;
  logic                serial_prox;
  logic                dado_reg, ocupado_reg, pronto_reg, abortado_reg;

  // The character on the line is always the low 7 bits of the shift register.
  assign char_atual = registro_prox[6:0];

  // Frame laid out LSB-first in transmission order, so quadro[bit index] is the line level.
  generate
    if (PARIDADE == 0) begin : g_sem_paridade
      assign quadro = {{STOP_BITS{1'b1}}, char_atual, 1'b0};
    end else if (PARIDADE == 1) begin : g_paridade_par
      assign quadro = {{STOP_BITS{1'b1}}, ^char_atual, char_atual, 1'b0};
    end else begin : g_paridade_impar
      assign quadro = {{STOP_BITS{1'b1}}, ~^char_atual, char_atual, 1'b0};
    end
  endgenerate

  always_comb begin
    estado_prox   = estado;
    baud_prox     = baud;
    bit_prox      = bit_idx;
    char_prox     = char_idx;
    registro_prox = registro;
    cancela_prox  = cancela;
    case (estado)
      OCIOSO: begin
        if (bus.iniciar) begin
          registro_prox = bus.caracteres;
          baud_prox     = '0;
          bit_prox      = '0;
          char_prox     = '0;
          cancela_prox  = 1'b0;
          estado_prox   = TRANSMITE;
        end
      end
      TRANSMITE: begin
        if (bus.cancelar) begin
          cancela_prox = 1'b1;
        end
        if (baud == BAUD_ULTIMO) begin
          baud_prox = '0;
          if (bit_idx == BIT_ULTIMO) begin
            // A pending cancel wins over both the next character and normal completion.
            bit_prox = '0;
            if (cancela_prox) begin
              estado_prox = CANCELADO;
            end else if (char_idx == CHAR_ULTIMO) begin
              estado_prox = FINAL;
            end else begin
              char_prox     = char_idx + 1'b1;
              registro_prox = registro >> 7;
            end
          end else begin
            bit_prox = bit_idx + 1'b1;
          end
        end else begin
          baud_prox = baud + 1'b1;
        end
      end
      FINAL:     estado_prox = OCIOSO;
      CANCELADO: estado_prox = OCIOSO;
      default:   estado_prox = OCIOSO;
    endcase
    serial_prox = (estado_prox == TRANSMITE) ? quadro[bit_prox] : 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado       <= OCIOSO;
      baud         <= '0;
      bit_idx      <= '0;
      char_idx     <= '0;
      registro     <= '0;
      cancela      <= 1'b0;
      dado_reg     <= 1'b1;
      ocupado_reg  <= 1'b0;
      pronto_reg   <= 1'b0;
      abortado_reg <= 1'b0;
    end else begin
      estado       <= estado_prox;
      baud         <= baud_prox;
      bit_idx      <= bit_prox;
      char_idx     <= char_prox;
      registro     <= registro_prox;
      cancela      <= cancela_prox;
      dado_reg     <= serial_prox;
      ocupado_reg  <= (estado_prox == TRANSMITE);
      pronto_reg   <= (estado_prox == FINAL);
      abortado_reg <= (estado_prox == CANCELADO);
    end
  end

  assign bus.dado_serial = dado_reg;
  assign bus.ocupado     = ocupado_reg;
  assign bus.pronto      = pronto_reg;
  assign bus.abortado    = abortado_reg;

endmodule
